// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and operation codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adder_pkg;

  localparam int   DEF_WIDTH  = 16;
  localparam int   DEF_STAGES = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder slice, one per pipeline stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic cy;

  // Ripple the carry bit by bit; remember the carry entering the top bit for overflow
  always_comb begin
    cy       = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_msb_in = cy;
      end
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub: one CHUNK-bit slice per stage, carries registered between stages.
// Latency: STAGES cycles from the accepting edge to out_valid; one beat per cycle throughput.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be an exact multiple of STAGES");
  end

  logic             adv;
  logic             v0;
  logic             c0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Capture rank: subtraction is folded in here as ~B with a forced carry-in of 1,
  // so the stages below never need to know the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      c0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) begin
        a0 <= a;
        b0 <= (sub == OP_SUB) ? ~b : b;
        c0 <= (sub == OP_ADD) ? cin : 1'b1;
      end else begin
        a0 <= '0;
        b0 <= '0;
        c0 <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still unconsumed when a beat reaches this stage
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         op_a;
    logic [REM-1:0]         op_b;
    logic                   vi;
    logic                   ci;
    logic [CHUNK-1:0]       s_c;
    logic                   co_c;
    logic                   cm_c;
    logic [(k+1)*CHUNK-1:0] s_d;
    logic [(k+1)*CHUNK-1:0] s_q;
    logic                   v_q;
    logic                   c_q;

    if (k == 0) begin : g_src
      assign op_a = a0;
      assign op_b = b0;
      assign vi   = v0;
      assign ci   = c0;
      assign s_d  = s_c;
    end else begin : g_src
      assign op_a = g_st[k-1].g_fwd.a_q;
      assign op_b = g_st[k-1].g_fwd.b_q;
      assign vi   = g_st[k-1].v_q;
      assign ci   = g_st[k-1].c_q;
      assign s_d  = {s_c, g_st[k-1].s_q};
    end

    chunk_add #(.CHUNK(CHUNK)) u_add (
      .a        (op_a[CHUNK-1:0]),
      .b        (op_b[CHUNK-1:0]),
      .ci       (ci),
      .s        (s_c),
      .co       (co_c),
      .c_msb_in (cm_c)
    );

    // Stage result rank: valid, carry to next slice and the sum chunks finished so far
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= co_c;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;
      logic                 unused_cm;

      // Only the top slice's MSB carry matters for signed overflow
      assign unused_cm = cm_c;

      // Skew rank: operand chunks not yet added travel alongside their beat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[REM-1:CHUNK];
          b_q <= op_b[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB disagrees with the carry out of it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cm_c ^ co_c;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed/random scoreboard bench for pipe_adder (WIDTH=16, STAGES=4).
// Expected results are pushed when a beat is accepted and popped when a result transfers.
// Checks reset state, latency, ordering, backpressure hold and mid-flight reset.
module tb_pipe_adder;
  import adder_pkg::*;

  localparam int W         = 16;
  localparam int S         = 4;
  // Push happens at the sample point before the accepting edge, the pop at the
  // sample point after the edge that raises out_valid: STAGES cycles + 1 tick.
  localparam int LAT_TICKS = S + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t q[$];
  exp_t pend;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference built from signed/unsigned integer arithmetic, not from carries
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    int   sx;
    int   sy;
    int   r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb == OP_SUB) begin
      r    = sx - sy;
      e.s  = x - y;
      e.co = (x >= y);
    end else begin
      r    = sx + sy + int'(ci);
      e.s  = x + y + W'(ci);
      e.co = (int'(x) + int'(y) + int'(ci)) > 65535;
    end
    e.ov  = (r > 32767) || (r < -32768);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic drive_lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input logic sb, input logic [W-1:0] es, input logic eco,
                           input logic eov);
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    pend.s = es; pend.co = eco; pend.ov = eov; pend.cyc = 0; pend.lat = 1'b1;
  endtask

  task automatic drive_mod(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input logic sb, input bit lat);
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    pend     = model(x, y, ci, sb);
    pend.lat = lat;
  endtask

  // One clock: settle, act as scoreboard for both handshakes, move to next negedge
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e     = pend;
      e.cyc = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        n_out++;
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(LAT_TICKS));
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int max_ticks);
    int n;
    n        = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < max_ticks) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int             start_out;
    logic [W-1:0]   rx;
    logic [W-1:0]   ry;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Carry through every chunk; accepted on the first edge after release
    drive_lit(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
    tick();
    drain(20);

    // Back-to-back add overflow then subtract with borrow
    drive_lit(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
    tick();
    drive_lit(16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    tick();
    drain(20);

    // 16-beat stream, chunk-boundary carries first, then random mixed add/sub
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       drive_mod(16'h0FFF, 16'h0001, 1'b0, OP_ADD, 1'b1);
        1:       drive_mod(16'h00FF, 16'h0001, 1'b0, OP_ADD, 1'b1);
        2:       drive_mod(16'h000F, 16'h0001, 1'b0, OP_ADD, 1'b1);
        3:       drive_mod(16'hFFFF, 16'h0000, 1'b1, OP_ADD, 1'b1);
        4:       drive_mod(16'h8000, 16'h0001, 1'b0, OP_SUB, 1'b1);
        5:       drive_mod(16'h0000, 16'h0000, 1'b1, OP_SUB, 1'b1);
        default: begin
          rx = W'($urandom);
          ry = W'($urandom);
          drive_mod(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
      endcase
      tick();
    end
    drain(20);

    // Fill the pipe with out_ready low, then hold for 6 cycles
    out_ready = 1'b0;
    for (int i = 0; i < S + 1; i++) begin
      drive_mod(16'h1000 * W'(i) + 16'h0FF1, 16'h0123 + W'(i), 1'b1, 1'(i % 2), 1'b0);
      tick();
    end
    drive_mod(16'hAAAA, 16'h5555, 1'b0, OP_ADD, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall sum", 32'(sum), 32'(q[0].s));
      chk("stall cout", 32'(cout), 32'(q[0].co));
      chk("stall ovf", 32'(ovf), 32'(q[0].ov));
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    start_out = n_out;
    for (int i = 0; i < S + 1; i++) tick();
    chk("drain one per cycle", 32'(n_out - start_out), 32'(S + 1));
    drain(10);

    // Three beats in flight, async reset mid-cycle while the first is at the output
    for (int i = 0; i < 3; i++) begin
      drive_mod(16'h0100 + W'(i), 16'h0011, 1'b0, OP_ADD, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst sum", 32'(sum), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_lit(16'h1234, 16'h1111, 1'b0, OP_ADD, 16'h2345, 1'b0, 1'b0);
    tick();
    drain(20);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("final queue empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
